// File: rtl/seq_frame_tx.sv
// seq_frame_tx: MSB-first 1101-preamble frame transmitter with zero-stuffing after any 110.
// Optional: define PARITY_EN to append an even-parity bit between payload and guard.
module seq_frame_tx #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data,
   output logic              ready,
   output logic              busy,
   output logic              z,
   output logic              stuff,
   output logic              frame_done
);
   localparam int CW = $clog2(DATA_W) < 2 ? 2 : $clog2(DATA_W);
`ifdef PARITY_EN
   typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GUARD} state_t;
   logic par;
`else
   typedef enum logic [2:0] {IDLE, PRE, DATA, GUARD} state_t;
`endif
   state_t state, ns;
   logic [CW-1:0] cnt, nc;
   logic [DATA_W-1:0] sr;
   logic [2:0] h;
   logic acc, cand, stf, last;
   assign ready = state == IDLE;
   assign busy = !ready;
   assign acc = start && ready;
   assign last = cnt == CW'(DATA_W - 1);
   // state/cnt describe the bit currently on z; ns/nc/cand describe the next real bit
   assign stf = h == 3'b110 && state != IDLE && ns != IDLE && !(ns == PRE && nc == CW'(3));
   always_comb begin
      ns = state;
      nc = cnt;
      cand = 1'b0;
      case (state)
         IDLE: begin
            ns = acc ? PRE : IDLE;
            nc = '0;
            cand = acc;
         end
         PRE: begin
            ns = cnt == CW'(3) ? DATA : PRE;
            nc = cnt == CW'(3) ? '0 : cnt + 1'b1;
            cand = cnt == CW'(3) ? sr[DATA_W-1] : cnt != CW'(1);
         end
         DATA: begin
`ifdef PARITY_EN
            ns = last ? PAR : DATA;
            cand = last ? par : sr[DATA_W-1];
`else
            ns = last ? GUARD : DATA;
            cand = last ? 1'b0 : sr[DATA_W-1];
`endif
            nc = last ? '0 : cnt + 1'b1;
         end
`ifdef PARITY_EN
         PAR: ns = GUARD;
`endif
         GUARD: ns = IDLE;
         default: ns = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         sr <= '0;
         h <= 3'b000;
         z <= 1'b0;
         stuff <= 1'b0;
         frame_done <= 1'b0;
`ifdef PARITY_EN
         par <= 1'b0;
`endif
      end else begin
         z <= stf ? 1'b0 : cand;
         h <= {h[1:0], stf ? 1'b0 : cand};
         stuff <= stf && ns != GUARD;
         frame_done <= !stf && ns == GUARD;
         if (!stf) begin
            state <= ns;
            cnt <= nc;
         end
         if (acc) begin
            sr <= data;
`ifdef PARITY_EN
            par <= ^data;
`endif
         end else if (!stf && ns == DATA) begin
            sr <= sr << 1;
         end
      end
   end
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: directed frames with hand-computed line patterns and a 1101 line detector.
module tb_seq_frame_tx;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [7:0] data = 8'h00;
   logic ready, busy, z, stuff, frame_done;
   logic [63:0] zv, sv, fv, bv;
   int fires, fire_at, n_chk = 0, n_fail = 0;

   seq_frame_tx #(.DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .data(data), .ready(ready),
      .busy(busy), .z(z), .stuff(stuff), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic hold);
      data = d;
      start = 1'b1;
      tick;
      start = hold;
   endtask

   // sample n line cycles, first sample lands in the MSB of an n-bit field
   task automatic cap(input int n);
      logic [3:0] hs = 4'b0000;
      zv = '0; sv = '0; fv = '0; bv = '0;
      fires = 0;
      fire_at = -1;
      for (int i = 0; i < n; i++) begin
         zv = {zv[62:0], z};
         sv = {sv[62:0], stuff};
         fv = {fv[62:0], frame_done};
         bv = {bv[62:0], busy};
         hs = {hs[2:0], z};
         if (hs == 4'b1101) begin
            fires++;
            fire_at = i;
         end
         tick;
      end
   endtask

   initial begin
      tick;
      chk("rst_z", z, 0);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_stuff", stuff, 0);
      chk("rst_done", frame_done, 0);
      rst = 1'b0;
      tick;
      tick;
      chk("idle_z", z, 0);

      send(8'h00, 1'b0);
      cap(13);
      chk("t1_z", zv, 13'b1101000000000);
      chk("t1_stuff", sv, 0);
      chk("t1_done", fv, 13'b0000000000001);
      chk("t1_busy", bv, 13'h1fff);
      chk("t1_fires", fires, 1);
      chk("t1_fire_at", fire_at, 3);
      chk("t1_ready_after", ready, 1);
      chk("t1_z_after", z, 0);
      tick;

      send(8'hB0, 1'b0);
      cap(15);
      chk("t2_z", zv, 15'b110110011000000);
      chk("t2_stuff", sv, 15'b000000100010000);
      chk("t2_done", fv, 15'b000000000000001);
      chk("t2_fires", fires, 1);
      chk("t2_fire_at", fire_at, 3);
      chk("t2_ready_after", ready, 1);
      tick;

      send(8'hDD, 1'b0);
      cap(15);
      chk("t3_z", zv, 15'b110111001110010);
      chk("t3_stuff", sv, 15'b000000010000100);
      chk("t3_done", fv, 15'b000000000000001);
      chk("t3_fires", fires, 1);
      chk("t3_busy", bv, 15'h7fff);
      tick;

      send(8'hFF, 1'b1);
      cap(42);
      chk("t4_z", zv, {3{14'b11011111111100}});
      chk("t4_stuff", sv, 0);
      chk("t4_done", fv, {3{14'b00000000000010}});
      chk("t4_busy", bv, {3{14'b11111111111110}});
      chk("t4_fires", fires, 3);
      start = 1'b0;
      for (int i = 0; i < 40 && !ready; i++) tick;
      chk("t4_idle", ready, 1);
      tick;

      send(8'hA5, 1'b0);
      cap(8);
      chk("t5_z_pre", zv, 8'b11011001);
      chk("t5_stuff_pre", sv, 8'b00000010);
      chk("t5_busy_pre", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_z_async", z, 0);
      chk("t5_busy_async", busy, 0);
      chk("t5_stuff_async", stuff, 0);
      chk("t5_ready_async", ready, 1);
      tick;
      rst = 1'b0;
      tick;
      chk("t5_ready_rel", ready, 1);
      send(8'h00, 1'b0);
      cap(13);
      chk("t5_z_new", zv, 13'b1101000000000);
      chk("t5_stuff_new", sv, 0);
      chk("t5_fires_new", fires, 1);
      tick;

      send(8'h01, 1'b0);
`ifdef PARITY_EN
      cap(14);
      chk("t6_z", zv, 14'b11010000000110);
      chk("t6_done", fv, 14'b00000000000001);
`else
      cap(13);
      chk("t6_z", zv, 13'b1101000000010);
      chk("t6_done", fv, 13'b0000000000001);
`endif
      chk("t6_stuff", sv, 0);
      chk("t6_ready_after", ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
